// File: rtl/sudoku_pkg.sv
// Shared constants for the 4x4 Sudoku move sequencer and its helpers:
// FSM state encodings, board size and the default write-ack timeout.
package sudoku_pkg;

    localparam int CELLS               = 16;
    localparam int ACK_TIMEOUT_DEFAULT = 15;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_DIFF       = 4'd1;
    localparam logic [3:0] ST_WAIT_BOARD = 4'd2;
    localparam logic [3:0] ST_ROW        = 4'd3;
    localparam logic [3:0] ST_COL        = 4'd4;
    localparam logic [3:0] ST_VAL        = 4'd5;
    localparam logic [3:0] ST_WRITE      = 4'd6;
    localparam logic [3:0] ST_CHECK      = 4'd7;
    localparam logic [3:0] ST_SOLVED     = 4'd8;

    localparam logic [CELLS-1:0] ALL_CELLS = '1;

    function automatic logic [CELLS-1:0] cell_onehot(input logic [3:0] addr);
        return {{(CELLS-1){1'b0}}, 1'b1} << addr;
    endfunction

endpackage

// File: rtl/sudoku_popcount16.sv
// Combinational population count of a 16-bit cell mask (0..16).
module sudoku_popcount16 (
    input  logic [15:0] bits,
    output logic [4:0]  count
);

    always_comb begin
        // NOTE: blocking '=' is right for an accumulator in combinational logic;
        // clocked state elsewhere uses '<=' so all flops update together.
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + {4'd0, bits[i]};
        end
    end

endmodule

// File: rtl/sudoku_move_sequencer.sv
// Move-entry controller: collects difficulty/row/col/value presses, runs the
// board write handshake with a timeout, then requests a check when the board is full.
module sudoku_move_sequencer
    import sudoku_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic             in_clka,
    input  logic             in_restart_n,
    input  logic             in_new_game,
    input  logic             in_enter,
    input  logic [1:0]       in_diff_cell_val,
    input  logic             in_board_ready,
    input  logic [CELLS-1:0] in_given_mask,
    output logic             out_wr_req,
    output logic [3:0]       out_wr_addr,
    output logic [2:0]       out_wr_val,
    input  logic             in_wr_ack,
    output logic             out_check_req,
    input  logic             in_check_done,
    input  logic             in_check_pass,
    output logic [1:0]       out_diff,
    output logic [3:0]       out_state,
    output logic             out_row_flag,
    output logic             out_col_flag,
    output logic             out_val_flag,
    output logic             out_check_flag,
    output logic             out_reject,
    output logic [4:0]       out_fill_cnt,
    output logic             out_solved
);

    localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [3:0]       state;
    logic [3:0]       state_next;
    logic [1:0]       row_q;
    logic [CELLS-1:0] filled;
    logic [CELLS-1:0] filled_next;
    logic [CNT_W-1:0] wr_cnt;
    logic             reject_next;
    logic [3:0]       press_addr;
    logic [4:0]       fill_cnt_comb;

    assign press_addr = {row_q, in_diff_cell_val};
    assign out_state  = state;

    sudoku_popcount16 u_fill_count (
        .bits  (in_given_mask | filled),
        .count (fill_cnt_comb)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_next  = state;
        filled_next = filled;
        reject_next = 1'b0;
        if (in_new_game && state != ST_IDLE) begin
            state_next  = ST_DIFF;
            filled_next = '0;
        end else begin
            case (state)
                ST_IDLE:       if (in_enter) state_next = ST_DIFF;
                ST_DIFF:       if (in_enter) state_next = ST_WAIT_BOARD;
                ST_WAIT_BOARD: if (in_board_ready) state_next = ST_ROW;
                ST_ROW:        if (in_enter) state_next = ST_COL;
                ST_COL: begin
                    if (in_enter) begin
                        if (in_given_mask[press_addr]) begin
                            reject_next = 1'b1;
                            state_next  = ST_ROW;
                        end else begin
                            state_next  = ST_VAL;
                        end
                    end
                end
                ST_VAL:        if (in_enter) state_next = ST_WRITE;
                ST_WRITE: begin
                    // An ack on the final counted cycle still wins over the timeout.
                    if (in_wr_ack) begin
                        filled_next = filled | cell_onehot(out_wr_addr);
                        state_next  = ((in_given_mask | filled_next) == ALL_CELLS) ? ST_CHECK : ST_ROW;
                    end else if (wr_cnt == CNT_LAST) begin
                        reject_next = 1'b1;
                        state_next  = ST_ROW;
                    end
                end
                ST_CHECK: begin
                    if (in_check_done) state_next = in_check_pass ? ST_SOLVED : ST_ROW;
                end
                ST_SOLVED:     state_next = ST_SOLVED;
                default:       state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state view so they line up with out_state.
    always_ff @(posedge in_clka) begin
        if (!in_restart_n) begin
            state          <= ST_IDLE;
            filled         <= '0;
            row_q          <= '0;
            wr_cnt         <= '0;
            out_wr_req     <= 1'b0;
            out_wr_addr    <= '0;
            out_wr_val     <= '0;
            out_check_req  <= 1'b0;
            out_diff       <= '0;
            out_row_flag   <= 1'b0;
            out_col_flag   <= 1'b0;
            out_val_flag   <= 1'b0;
            out_check_flag <= 1'b0;
            out_reject     <= 1'b0;
            out_fill_cnt   <= '0;
            out_solved     <= 1'b0;
        end else begin
            // NOTE: non-blocking '<=' for all state so every flop samples pre-edge values.
            state          <= state_next;
            filled         <= filled_next;
            out_reject     <= reject_next;
            out_fill_cnt   <= fill_cnt_comb;
            out_wr_req     <= (state_next == ST_WRITE);
            out_check_req  <= (state_next == ST_CHECK);
            out_row_flag   <= (state_next == ST_ROW);
            out_col_flag   <= (state_next == ST_COL);
            out_val_flag   <= (state_next == ST_VAL);
            out_check_flag <= (state_next == ST_CHECK);
            out_solved     <= (state_next == ST_SOLVED);

            if (state == ST_WRITE && state_next == ST_WRITE) wr_cnt <= wr_cnt + CNT_W'(1);
            else                                             wr_cnt <= '0;

            if (state == ST_DIFF && state_next == ST_WAIT_BOARD) out_diff <= in_diff_cell_val;
            if (state == ST_ROW && state_next == ST_COL)         row_q <= in_diff_cell_val;
            if (state == ST_COL && state_next == ST_VAL)         out_wr_addr <= press_addr;
            if (state == ST_VAL && state_next == ST_WRITE)       out_wr_val <= {1'b0, in_diff_cell_val} + 3'd1;
        end
    end

endmodule

// File: tb/tb_sudoku_move_sequencer.sv
// Scoreboard bench: the driver plays randomized moves against a transaction-level
// game model and queues expected handshakes; a monitor checks what the DUT presents.
module tb_sudoku_move_sequencer;

    localparam int S_IDLE = 0, S_DIFF = 1, S_WAIT = 2, S_ROW = 3, S_COL = 4,
                   S_VAL = 5, S_CHECK = 7, S_SOLVED = 8;
    localparam int ACK_TO = 15;

    typedef enum int {EV_WR, EV_REJ, EV_CHK} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [3:0] addr;
        logic [2:0] val;
        int         width;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_new_game, in_enter, in_board_ready;
    logic [1:0]  in_diff_cell_val;
    logic [15:0] in_given_mask;
    logic        in_wr_ack, in_check_done, in_check_pass;
    logic        out_wr_req, out_check_req, out_reject, out_solved;
    logic [3:0]  out_wr_addr, out_state;
    logic [2:0]  out_wr_val;
    logic [1:0]  out_diff;
    logic        out_row_flag, out_col_flag, out_val_flag, out_check_flag;
    logic [4:0]  out_fill_cnt;

    always #5 clk = ~clk;

    sudoku_move_sequencer #(.ACK_TIMEOUT(ACK_TO)) dut (
        .in_clka          (clk),
        .in_restart_n     (rst_n),
        .in_new_game      (in_new_game),
        .in_enter         (in_enter),
        .in_diff_cell_val (in_diff_cell_val),
        .in_board_ready   (in_board_ready),
        .in_given_mask    (in_given_mask),
        .out_wr_req       (out_wr_req),
        .out_wr_addr      (out_wr_addr),
        .out_wr_val       (out_wr_val),
        .in_wr_ack        (in_wr_ack),
        .out_check_req    (out_check_req),
        .in_check_done    (in_check_done),
        .in_check_pass    (in_check_pass),
        .out_diff         (out_diff),
        .out_state        (out_state),
        .out_row_flag     (out_row_flag),
        .out_col_flag     (out_col_flag),
        .out_val_flag     (out_val_flag),
        .out_check_flag   (out_check_flag),
        .out_reject       (out_reject),
        .out_fill_cnt     (out_fill_cnt),
        .out_solved       (out_solved)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    ev_t         exp_q[$];
    logic [15:0] m_given;
    logic [15:0] m_filled;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ev_t mk_ev(ev_kind_t k, logic [3:0] a, logic [2:0] v, int w);
        ev_t e;
        e.kind = k; e.addr = a; e.val = v; e.width = w;
        return e;
    endfunction

    task automatic pop_expect(input ev_kind_t k, output ev_t ev);
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event %s: got unexpected event, expected nothing queued", k.name());
            ev = mk_ev(k, 4'd0, 3'd0, 0);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind != k) begin
                n_fail++;
                $display("FAIL event order: got %s expected %s", k.name(), ev.kind.name());
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_wr = 1'b0, prev_chk = 1'b0, prev_rej = 1'b0;
    ev_t  cur_wr, cur_chk, cur_rej;
    int   wr_len = 0, chk_len = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_wr_req && !prev_wr) begin
                pop_expect(EV_WR, cur_wr);
                wr_len = 1;
                check("wr_addr", 32'(out_wr_addr), 32'(cur_wr.addr));
                check("wr_val", 32'(out_wr_val), 32'(cur_wr.val));
            end else if (out_wr_req) begin
                wr_len++;
                check("wr_addr stable", 32'(out_wr_addr), 32'(cur_wr.addr));
                check("wr_val stable", 32'(out_wr_val), 32'(cur_wr.val));
            end else if (prev_wr) begin
                check("wr_req width", 32'(wr_len), 32'(cur_wr.width));
            end

            if (out_check_req && !prev_chk) begin
                pop_expect(EV_CHK, cur_chk);
                chk_len = 1;
            end else if (out_check_req) begin
                chk_len++;
            end else if (prev_chk) begin
                check("check_req width", 32'(chk_len), 32'(cur_chk.width));
            end

            if (out_reject && !prev_rej) pop_expect(EV_REJ, cur_rej);
            if (prev_rej) check("reject one cycle", 32'(out_reject), 32'd0);
        end
        prev_wr  = out_wr_req;
        prev_chk = out_check_req;
        prev_rej = out_reject;
    end

    // ---------------- driver / model ----------------
    task automatic press(input logic [1:0] d);
        @(negedge clk);
        in_diff_cell_val = d;
        in_enter         = 1'b1;
        in_wr_ack        = 1'($urandom_range(0, 1));
        in_check_done    = 1'($urandom_range(0, 1));
        in_check_pass    = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_enter         = 1'b0;
        in_wr_ack        = 1'b0;
        in_check_done    = 1'b0;
        in_diff_cell_val = 2'($urandom_range(0, 3));
    endtask

    task automatic clear_strobes();
        in_enter = 1'b0; in_wr_ack = 1'b0; in_check_done = 1'b0; in_check_pass = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] r, input logic [1:0] c, input logic [1:0] v,
                           input int ad, input int dd, input bit pass, output bit solved);
        logic [3:0] addr;
        bit         acked;
        bit         full;
        int         n_wr;
        addr   = {r, c};
        solved = 1'b0;
        press(r);
        check("state after row press", 32'(out_state), S_COL);
        check("col flag", 32'(out_col_flag), 32'd1);
        if (m_given[addr]) begin
            exp_q.push_back(mk_ev(EV_REJ, addr, 3'd0, 1));
            press(c);
            check("state after given reject", 32'(out_state), S_ROW);
            check("wr_req after reject", 32'(out_wr_req), 32'd0);
            return;
        end
        press(c);
        check("state after col press", 32'(out_state), S_VAL);
        check("val flag", 32'(out_val_flag), 32'd1);
        acked = (ad <= ACK_TO - 1);
        n_wr  = acked ? ad + 1 : ACK_TO;
        exp_q.push_back(mk_ev(EV_WR, addr, {1'b0, v} + 3'd1, n_wr));
        full = 1'b0;
        if (acked) begin
            m_filled[addr] = 1'b1;
            full = ((m_given | m_filled) == 16'hFFFF);
        end else begin
            exp_q.push_back(mk_ev(EV_REJ, addr, 3'd0, 1));
        end
        if (full) exp_q.push_back(mk_ev(EV_CHK, addr, 3'd0, dd + 2));
        press(v);
        for (int i = 0; i < n_wr; i++) begin
            in_wr_ack     = (i == ad);
            in_enter      = 1'($urandom_range(0, 1));
            in_check_done = 1'($urandom_range(0, 1));
            in_check_pass = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        clear_strobes();
        check("state after write", 32'(out_state), full ? S_CHECK : S_ROW);
        @(negedge clk);
        check("fill count", 32'(out_fill_cnt), 32'($countones(m_given | m_filled)));
        if (full) begin
            check("check flag", 32'(out_check_flag), 32'd1);
            for (int i = 0; i <= dd; i++) begin
                in_check_done = (i == dd);
                in_check_pass = (i == dd) ? pass : 1'($urandom_range(0, 1));
                in_wr_ack     = 1'($urandom_range(0, 1));
                in_enter      = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            clear_strobes();
            check("state after check", 32'(out_state), pass ? S_SOLVED : S_ROW);
            check("solved", 32'(out_solved), 32'(pass));
            solved = pass;
        end
    endtask

    task automatic new_game(input logic [15:0] mask);
        @(negedge clk);
        in_new_game   = 1'b1;
        in_given_mask = mask;
        @(negedge clk);
        in_new_game = 1'b0;
        m_given  = mask;
        m_filled = '0;
        check("state after new_game", 32'(out_state), S_DIFF);
        check("solved after new_game", 32'(out_solved), 32'd0);
        check("check_req after new_game", 32'(out_check_req), 32'd0);
    endtask

    task automatic enter_diff_board(input logic [1:0] d);
        int k;
        press(d);
        check("state after diff", 32'(out_state), S_WAIT);
        check("latched diff", 32'(out_diff), 32'(d));
        k = int'($urandom_range(0, 2));
        for (int i = 0; i < k; i++) press(2'($urandom_range(0, 3)));
        check("presses ignored in wait_board", 32'(out_state), S_WAIT);
        @(negedge clk) in_board_ready = 1'b1;
        @(negedge clk) in_board_ready = 1'b0;
        check("state after board ready", 32'(out_state), S_ROW);
        check("row flag", 32'(out_row_flag), 32'd1);
    endtask

    task automatic new_game_mid_write(input logic [1:0] r, input logic [1:0] c, input logic [1:0] v);
        press(r);
        press(c);
        exp_q.push_back(mk_ev(EV_WR, {r, c}, {1'b0, v} + 3'd1, 1));
        press(v);
        in_new_game = 1'b1;
        in_wr_ack   = 1'b1;
        @(negedge clk);
        in_new_game = 1'b0;
        in_wr_ack   = 1'b0;
        m_filled    = '0;
        check("state after mid-write new_game", 32'(out_state), S_DIFF);
        check("wr_req after mid-write new_game", 32'(out_wr_req), 32'd0);
        @(negedge clk);
        check("fill count given-only", 32'(out_fill_cnt), 32'($countones(m_given)));
    endtask

    task automatic play_game();
        bit solved;
        solved = 1'b0;
        for (int m = 0; m < 60 && !solved; m++) begin
            logic [3:0] a;
            logic [3:0] cand;
            bit         found;
            int         sel;
            int         ad;
            found = 1'b0;
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 7) begin
                for (int k = 0; k < 16; k++) begin
                    cand = a + 4'(k);
                    if (!found && !m_given[cand] && !m_filled[cand]) begin
                        found = 1'b1;
                        a = cand;
                    end
                end
            end
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      ad = int'($urandom_range(0, 3));
            else if (sel < 9) ad = int'($urandom_range(12, 14));
            else              ad = int'($urandom_range(15, 18));
            do_move(a[3:2], a[1:0], 2'($urandom_range(0, 3)), ad,
                    int'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, solved);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         s;
        logic [3:0] a;
        rst_n = 1'b0;
        in_new_game = 1'b0; in_board_ready = 1'b0; in_diff_cell_val = 2'd0;
        clear_strobes();
        in_given_mask = 16'h000F;
        m_given  = 16'h000F;
        m_filled = '0;
        repeat (3) @(negedge clk);
        check("reset state", 32'(out_state), S_IDLE);
        check("reset wr_req", 32'(out_wr_req), 32'd0);
        check("reset check_req", 32'(out_check_req), 32'd0);
        check("reset reject", 32'(out_reject), 32'd0);
        check("reset solved", 32'(out_solved), 32'd0);
        check("reset flags", 32'({out_row_flag, out_col_flag, out_val_flag, out_check_flag}), 32'd0);
        check("reset diff", 32'(out_diff), 32'd0);
        check("reset wr_addr", 32'(out_wr_addr), 32'd0);
        check("reset wr_val", 32'(out_wr_val), 32'd0);
        check("reset fill_cnt", 32'(out_fill_cnt), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        press(2'd0);
        check("state after idle press", 32'(out_state), S_DIFF);
        enter_diff_board(2'd2);
        check("fill count from given", 32'(out_fill_cnt), 32'd4);

        do_move(2'd0, 2'd1, 2'd2, 0, 0, 1'b0, s);
        do_move(2'd2, 2'd3, 2'd1, 2, 0, 1'b0, s);
        check("directed fill count", 32'(out_fill_cnt), 32'd5);
        do_move(2'd3, 2'd0, 2'd0, 20, 0, 1'b0, s);
        check("state after timeout", 32'(out_state), S_ROW);

        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            if (!m_given[a] && !m_filled[a])
                do_move(a[3:2], a[1:0], 2'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 2, 1'b0, s);
        end
        do_move(2'd2, 2'd3, 2'd3, 0, 3, 1'b1, s);

        new_game(16'h00F0);
        enter_diff_board(2'd1);
        do_move(2'd0, 2'd0, 2'd3, 1, 0, 1'b0, s);
        new_game_mid_write(2'd3, 2'd3, 2'd2);
        enter_diff_board(2'd3);

        for (int g = 0; g < 5; g++) begin
            play_game();
            new_game(16'($urandom | $urandom));
            enter_diff_board(2'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        check("events left unmatched", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
